// File: rtl/uart_loader_pkg.sv
// Shared types and constants for the UART memory loader: FSM state encoding,
// command codes, default framing bytes and a byte-count helper.
package uart_loader_pkg;

    // Loader FSM states. The receive states run from CMD through STOP.
    // WRITE and CLEAR are the output phases.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CMD   = 3'd1,
        ST_ADDR  = 3'd2,
        ST_DATA  = 3'd3,
        ST_CHK   = 3'd4,
        ST_STOP  = 3'd5,
        ST_WRITE = 3'd6,
        ST_CLEAR = 3'd7
    } state_t;

    // Command byte values, compared after unescaping
    localparam logic [7:0] CMD_WRITE = 8'h01;
    localparam logic [7:0] CMD_CLEAR = 8'h02;

    // Default raw framing bytes
    localparam logic [7:0] DEF_START_BYTE = 8'h55;
    localparam logic [7:0] DEF_STOP_BYTE  = 8'hAA;
    localparam logic [7:0] DEF_ESC_BYTE   = 8'h7D;

    // An escaped byte is recovered by XOR with this mask
    localparam logic [7:0] ESC_XOR = 8'h20;

    // Number of whole bytes needed to carry a field of the given bit width
    function automatic int bytes_for(input int bits);
        return (bits + 7) / 8;
    endfunction

endpackage

// File: rtl/uart_unescape.sv
// Byte classifier and unescaper placed in front of the loader FSM.
// It flags raw START/STOP bytes, swallows ESC prefixes and delivers the
// de-escaped payload byte together with a data_valid strobe.
module uart_unescape
    import uart_loader_pkg::*;
#(
    parameter logic [7:0] START_BYTE = DEF_START_BYTE,
    parameter logic [7:0] STOP_BYTE  = DEF_STOP_BYTE,
    parameter logic [7:0] ESC_BYTE   = DEF_ESC_BYTE
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       flush,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [7:0] data,
    output logic       is_start,
    output logic       is_stop,
    output logic       data_valid
);

    logic esc_reg;
    logic is_esc;

    // Classify the incoming raw byte. A raw START/STOP is always framing,
    // even right after ESC. An ESC that follows an ESC is payload.
    always_comb begin
        is_start   = rx_valid && (rx_data == START_BYTE);
        is_stop    = rx_valid && (rx_data == STOP_BYTE);
        is_esc     = rx_valid && !esc_reg && (rx_data == ESC_BYTE);
        data_valid = rx_valid && !is_start && !is_stop && !is_esc;
        data       = esc_reg ? (rx_data ^ ESC_XOR) : rx_data;
    end

    // Escape flag: armed by a raw ESC and consumed by the next payload byte.
    // Framing bytes and the flush input drop a dangling escape, so it cannot
    // leak from one frame into the next.
    always_ff @(posedge clk) begin
        if (rst) begin
            esc_reg <= 1'b0;
        end else if (flush || is_start || is_stop) begin
            esc_reg <= 1'b0;
        end else if (is_esc) begin
            esc_reg <= 1'b1;
        end else if (data_valid) begin
            esc_reg <= 1'b0;
        end
    end

endmodule

// File: rtl/uart_mem_loader.sv
// UART command-frame loader. It decodes escaped, checksummed frames from the
// uart_rx byte stream into memory writes (single word or full clear). It holds
// the CPU via busy while a frame is in progress and counts framing errors.
module uart_mem_loader
    import uart_loader_pkg::*;
#(
    parameter int         ADDR_W     = 10,
    parameter int         DATA_W     = 12,
    parameter logic [7:0] START_BYTE = DEF_START_BYTE,
    parameter logic [7:0] STOP_BYTE  = DEF_STOP_BYTE,
    parameter logic [7:0] ESC_BYTE   = DEF_ESC_BYTE
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              mem_wr_en,
    output logic [ADDR_W-1:0] mem_wr_addr,
    output logic [DATA_W-1:0] mem_wr_data,
    output logic              busy,
    output logic              frame_ok,
    output logic              frame_err,
    output logic [7:0]        err_count
);

    // Address and data fields are sent MSB first in whole bytes (at most 2
    // each for widths up to 16). The byte counter only has to reach 1.
    localparam int          AB        = bytes_for(ADDR_W);
    localparam int          DB        = bytes_for(DATA_W);
    localparam logic [1:0]  AB_LAST   = 2'(AB - 1);
    localparam logic [1:0]  DB_LAST   = 2'(DB - 1);
    localparam logic [ADDR_W-1:0] CLR_LAST = '1;

    state_t            state_reg,    state_next;
    logic [7:0]        cmd_reg,      cmd_next;
    logic [7:0]        sum_reg,      sum_next;
    logic [1:0]        cnt_reg,      cnt_next;
    logic [ADDR_W-1:0] addr_reg,     addr_next;
    logic [DATA_W-1:0] data_reg,     data_next;
    logic [ADDR_W-1:0] clr_addr_reg, clr_addr_next;
    logic [7:0]        err_cnt_reg,  err_cnt_next;
    logic              frame_err_reg;
    logic              err_event;

    logic [7:0]        rx_byte;
    logic              rx_start;
    logic              rx_stop;
    logic              rx_data_valid;
    logic              unesc_flush;

    // Outside the receive states a dangling escape has no meaning
    assign unesc_flush = (state_reg == ST_IDLE) || (state_reg == ST_WRITE) ||
                         (state_reg == ST_CLEAR);

    uart_unescape #(
        .START_BYTE (START_BYTE),
        .STOP_BYTE  (STOP_BYTE),
        .ESC_BYTE   (ESC_BYTE)
    ) u_unescape (
        .clk        (clk),
        .rst        (rst),
        .flush      (unesc_flush),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .data       (rx_byte),
        .is_start   (rx_start),
        .is_stop    (rx_stop),
        .data_valid (rx_data_valid)
    );

    // Frame decoder: next-state, field capture, running checksum and error detection
    always_comb begin
        state_next    = state_reg;
        cmd_next      = cmd_reg;
        sum_next      = sum_reg;
        cnt_next      = cnt_reg;
        addr_next     = addr_reg;
        data_next     = data_reg;
        clr_addr_next = clr_addr_reg;
        err_event     = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                // Only a raw START matters here. Line noise is ignored silently.
                if (rx_start) begin
                    state_next = ST_CMD;
                    sum_next   = 8'h00;
                    cnt_next   = 2'd0;
                end
            end

            ST_WRITE: begin
                // Single output cycle. A byte arriving now cannot be framed.
                state_next = ST_IDLE;
                if (rx_valid) begin
                    err_event = 1'b1;
                end
            end

            ST_CLEAR: begin
                // The clear always completes. Stray bytes are dropped and counted.
                if (rx_valid) begin
                    err_event = 1'b1;
                end
                clr_addr_next = clr_addr_reg + 1'b1;
                if (clr_addr_reg == CLR_LAST) begin
                    state_next = ST_IDLE;
                end
            end

            default: begin
                // Receive states CMD..STOP
                if (rx_start) begin
                    // Resync: abandon the partial frame and start a new one at once
                    err_event  = 1'b1;
                    state_next = ST_CMD;
                    sum_next   = 8'h00;
                    cnt_next   = 2'd0;
                end else if (state_reg == ST_STOP) begin
                    if (rx_stop) begin
                        if (sum_reg == 8'h00) begin
                            state_next    = (cmd_reg == CMD_WRITE) ? ST_WRITE : ST_CLEAR;
                            clr_addr_next = '0;
                        end else begin
                            err_event  = 1'b1;
                            state_next = ST_IDLE;
                        end
                    end else if (rx_valid) begin
                        // Anything other than STOP (an ESC prefix included) breaks the frame
                        err_event  = 1'b1;
                        state_next = ST_IDLE;
                    end
                end else if (rx_stop) begin
                    // Frame closed before all of its fields arrived
                    err_event  = 1'b1;
                    state_next = ST_IDLE;
                end else if (rx_data_valid) begin
                    sum_next = sum_reg + rx_byte;
                    case (state_reg)
                        ST_CMD: begin
                            cmd_next = rx_byte;
                            if (rx_byte == CMD_WRITE) begin
                                state_next = ST_ADDR;
                                cnt_next   = 2'd0;
                            end else if (rx_byte == CMD_CLEAR) begin
                                state_next = ST_CHK;
                            end else begin
                                err_event  = 1'b1;
                                state_next = ST_IDLE;
                            end
                        end
                        ST_ADDR: begin
                            // Shift in MSB-first. Bits above ADDR_W fall off the top.
                            addr_next = ADDR_W'({addr_reg, rx_byte});
                            if (cnt_reg == AB_LAST) begin
                                state_next = ST_DATA;
                                cnt_next   = 2'd0;
                            end else begin
                                cnt_next = cnt_reg + 2'd1;
                            end
                        end
                        ST_DATA: begin
                            data_next = DATA_W'({data_reg, rx_byte});
                            if (cnt_reg == DB_LAST) begin
                                state_next = ST_CHK;
                                cnt_next   = 2'd0;
                            end else begin
                                cnt_next = cnt_reg + 2'd1;
                            end
                        end
                        ST_CHK: begin
                            state_next = ST_STOP;
                        end
                        default: begin
                        end
                    endcase
                end
            end
        endcase
    end

    // Error counter saturates at 255 so a noisy link cannot wrap it to zero
    always_comb begin
        err_cnt_next = err_cnt_reg;
        if (err_event && (err_cnt_reg != 8'hFF)) begin
            err_cnt_next = err_cnt_reg + 8'd1;
        end
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            cmd_reg       <= 8'h00;
            sum_reg       <= 8'h00;
            cnt_reg       <= 2'd0;
            addr_reg      <= '0;
            data_reg      <= '0;
            clr_addr_reg  <= '0;
            err_cnt_reg   <= 8'h00;
            frame_err_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cmd_reg       <= cmd_next;
            sum_reg       <= sum_next;
            cnt_reg       <= cnt_next;
            addr_reg      <= addr_next;
            data_reg      <= data_next;
            clr_addr_reg  <= clr_addr_next;
            err_cnt_reg   <= err_cnt_next;
            frame_err_reg <= err_event;
        end
    end

    // Moore outputs decoded from the registered state. A reset therefore
    // drops mem_wr_en on the very edge that returns the FSM to IDLE.
    always_comb begin
        mem_wr_en   = (state_reg == ST_WRITE) || (state_reg == ST_CLEAR);
        mem_wr_addr = '0;
        mem_wr_data = '0;
        if (state_reg == ST_WRITE) begin
            mem_wr_addr = addr_reg;
            mem_wr_data = data_reg;
        end else if (state_reg == ST_CLEAR) begin
            mem_wr_addr = clr_addr_reg;
        end
        busy      = (state_reg != ST_IDLE);
        frame_ok  = (state_reg == ST_WRITE) ||
                    ((state_reg == ST_CLEAR) && (clr_addr_reg == CLR_LAST));
        frame_err = frame_err_reg;
        err_count = err_cnt_reg;
    end

endmodule

// File: tb/tb_uart_mem_loader.sv
// Self-checking bench for uart_mem_loader. It drives directed frame vectors
// from a table, randomised frames whose expected outcome follows from how
// each frame was built, and hand-written clear, saturation and reset sequences.
module tb_uart_mem_loader;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 12;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [7:0]        rx_data = 8'h00;
    logic              rx_valid = 1'b0;
    logic              mem_wr_en;
    logic [ADDR_W-1:0] mem_wr_addr;
    logic [DATA_W-1:0] mem_wr_data;
    logic              busy;
    logic              frame_ok;
    logic              frame_err;
    logic [7:0]        err_count;

    always #5 clk = ~clk;

    uart_mem_loader #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .mem_wr_en   (mem_wr_en),
        .mem_wr_addr (mem_wr_addr),
        .mem_wr_data (mem_wr_data),
        .busy        (busy),
        .frame_ok    (frame_ok),
        .frame_err   (frame_err),
        .err_count   (err_count)
    );

    int checks = 0;
    int errors = 0;
    int exp_err_total = 0;

    // Observation log, filled on the falling edge, away from the active edge
    logic [ADDR_W-1:0] wr_addr_q[$];
    logic [DATA_W-1:0] wr_data_q[$];
    int                wr_cyc_q[$];
    int                cyc = 0;
    int                ok_n = 0;
    int                errp_n = 0;
    int                ok_last_addr = -1;
    int                wr_no_busy = 0;

    always @(negedge clk) begin
        cyc++;
        if (mem_wr_en) begin
            wr_addr_q.push_back(mem_wr_addr);
            wr_data_q.push_back(mem_wr_data);
            wr_cyc_q.push_back(cyc);
            if (!busy) wr_no_busy++;
        end
        if (frame_ok) begin
            ok_n++;
            ok_last_addr = int'(mem_wr_addr);
        end
        if (frame_err) errp_n++;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic wait_idle(input int limit, input string name);
        int n;
        n = 0;
        while (busy && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (busy) check({name, " busy_timeout"}, 1, 0);
        repeat (3) @(negedge clk);
    endtask

    function automatic bit is_special(input logic [7:0] b);
        return (b == 8'h55) || (b == 8'hAA) || (b == 8'h7D);
    endfunction

    logic [7:0] frame_q[$];

    // Payload byte onto the wire: specials must be escaped, others sometimes are
    task automatic push_esc(input logic [7:0] b);
        logic [7:0] x;
        x = b ^ 8'h20;
        if (is_special(b) || (($urandom_range(0, 3) == 0) && !is_special(x))) begin
            frame_q.push_back(8'h7D);
            frame_q.push_back(x);
        end else begin
            frame_q.push_back(b);
        end
    endtask

    // Send frame_q and compare the outcome with the expected one
    task automatic run_frame(input string name, input int exp_wr, input int exp_addr,
                             input int exp_data, input int exp_err);
        int base_wr, base_ok, base_err, got_wr;
        base_wr  = wr_addr_q.size();
        base_ok  = ok_n;
        base_err = errp_n;
        foreach (frame_q[k]) send_byte(frame_q[k], int'($urandom_range(0, 2)));
        wait_idle(200, name);
        got_wr = wr_addr_q.size() - base_wr;
        check({name, " writes"}, got_wr, exp_wr);
        if (got_wr == 1 && exp_wr == 1) begin
            check({name, " addr"}, int'(wr_addr_q[base_wr]), exp_addr);
            check({name, " data"}, int'(wr_data_q[base_wr]), exp_data);
        end
        check({name, " frame_ok"}, ok_n - base_ok, exp_wr);
        check({name, " frame_err"}, errp_n - base_err, exp_err);
        exp_err_total = (exp_err_total + exp_err > 255) ? 255 : exp_err_total + exp_err;
        check({name, " err_count"}, int'(err_count), exp_err_total);
        check({name, " busy_after"}, int'(busy), 0);
        $display("frame %s: bytes=%0d writes=%0d err_count=%0d", name, frame_q.size(), got_wr, err_count);
    endtask

    typedef struct {
        string        name;
        logic [127:0] raw;
        int           len;
        int           exp_wr;
        int           exp_addr;
        int           exp_data;
        int           exp_err;
    } vec_t;

    vec_t vecs[9];

    initial begin
        int          base, n, bad, hit;
        logic [31:0] r;
        logic [7:0]  cmd, ah, al, dh, dl, s, chk;
        logic [15:0] aw, dw;
        int          kind;

        vecs[0] = '{"plain",       128'h5501_0123_0ABC_15AA,      8,  1, 'h123, 'hABC, 0};
        vecs[1] = '{"escaped",     128'h5501_007D_7500_7D8A_00AA, 10, 1, 'h055, 'h0AA, 0};
        vecs[2] = '{"bad_chk",     128'h5501_0123_0ABC_16AA,      8,  0, 0, 0, 1};
        vecs[3] = '{"resync",      128'h550101_5501_0123_0ABC_15AA, 11, 1, 'h123, 'hABC, 1};
        vecs[4] = '{"junk_idle",   128'h1234,                     2,  0, 0, 0, 0};
        vecs[5] = '{"bad_cmd",     128'h5507_F9AA,                4,  0, 0, 0, 1};
        vecs[6] = '{"early_stop",  128'h5501_01AA,                4,  0, 0, 0, 1};
        vecs[7] = '{"stop_garbage",128'h5502_FE00AA,              5,  0, 0, 0, 1};
        vecs[8] = '{"stop_in_cmd", 128'h55AA,                     2,  0, 0, 0, 1};

        // Reset state
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("reset mem_wr_en",   int'(mem_wr_en), 0);
        check("reset mem_wr_addr", int'(mem_wr_addr), 0);
        check("reset mem_wr_data", int'(mem_wr_data), 0);
        check("reset busy",        int'(busy), 0);
        check("reset frame_ok",    int'(frame_ok), 0);
        check("reset frame_err",   int'(frame_err), 0);
        check("reset err_count",   int'(err_count), 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Directed frame table
        for (int i = 0; i < 9; i++) begin
            frame_q.delete();
            for (int k = 0; k < vecs[i].len; k++)
                frame_q.push_back(vecs[i].raw[8*(vecs[i].len-1-k) +: 8]);
            run_frame(vecs[i].name, vecs[i].exp_wr, vecs[i].exp_addr, vecs[i].exp_data, vecs[i].exp_err);
        end

        // Randomised frames: the expected outcome follows from how each one is built
        for (int i = 0; i < 40; i++) begin
            r = $urandom; ah = r[31:24]; al = r[23:16]; dh = r[15:8]; dl = r[7:0];
            aw = {ah, al};
            dw = {dh, dl};
            kind = int'($urandom_range(0, 4));
            frame_q.delete();
            frame_q.push_back(8'h55);
            if (kind <= 2) begin
                cmd = 8'h01;
                s   = cmd + ah + al + dh + dl;
                chk = 8'h00 - s;
                if (kind == 2) chk = chk + 8'(1 + $urandom_range(0, 254));
                push_esc(cmd); push_esc(ah); push_esc(al); push_esc(dh); push_esc(dl); push_esc(chk);
                frame_q.push_back(8'hAA);
                if (kind == 2) run_frame("rand_badchk", 0, 0, 0, 1);
                else run_frame("rand_write", 1, int'(aw[ADDR_W-1:0]), int'(dw[DATA_W-1:0]), 0);
            end else if (kind == 3) begin
                cmd = 8'($urandom_range(3, 'h54));
                frame_q.push_back(cmd);
                frame_q.push_back(8'hAA);
                run_frame("rand_badcmd", 0, 0, 0, 1);
            end else begin
                push_esc(8'h01); push_esc(ah);
                frame_q.push_back(8'hAA);
                run_frame("rand_short", 0, 0, 0, 1);
            end
        end

        // Full clear: 1024 back-to-back zero writes, frame_ok on the last
        base = wr_addr_q.size();
        n = ok_n;
        wr_no_busy = 0;
        frame_q = '{8'h55, 8'h02, 8'hFE, 8'hAA};
        foreach (frame_q[k]) send_byte(frame_q[k], 1);
        wait_idle(3000, "clear");
        check("clear writes", wr_addr_q.size() - base, 1024);
        bad = 0;
        if (wr_addr_q.size() - base == 1024) begin
            for (int k = 0; k < 1024; k++)
                if (int'(wr_addr_q[base+k]) != k || wr_data_q[base+k] != '0) bad++;
            check("clear span_cycles", wr_cyc_q[base+1023] - wr_cyc_q[base], 1023);
        end
        check("clear sequence", bad, 0);
        check("clear frame_ok", ok_n - n, 1);
        check("clear ok_addr", ok_last_addr, 1023);
        check("clear busy_during", wr_no_busy, 0);
        $display("frame clear: writes=%0d err_count=%0d", wr_addr_q.size() - base, err_count);

        // Saturation: 300 bad-command frames
        n = errp_n;
        for (int i = 0; i < 300; i++) begin
            send_byte(8'h55, 0); send_byte(8'h07, 0); send_byte(8'hF9, 0); send_byte(8'hAA, 0);
        end
        repeat (3) @(negedge clk);
        check("sat pulses", errp_n - n, 300);
        check("sat err_count", int'(err_count), 255);
        exp_err_total = 255;
        $display("frame saturation: err_count=%0d", err_count);
        frame_q = '{8'h12, 8'h34};
        run_frame("junk_after_sat", 0, 0, 0, 0);

        // Reset in the middle of a clear
        base = wr_addr_q.size();
        frame_q = '{8'h55, 8'h02, 8'hFE, 8'hAA};
        foreach (frame_q[k]) send_byte(frame_q[k], 0);
        hit = 0;
        n = 0;
        while (hit == 0 && n < 2000) begin
            @(negedge clk);
            n++;
            if (mem_wr_en && mem_wr_addr == 10'd500) hit = 1;
        end
        check("rst_clear reached_500", hit, 1);
        rst = 1'b1;
        @(negedge clk);
        check("rst_clear wr_en_dropped", int'(mem_wr_en), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        check("rst_clear writes", wr_addr_q.size() - base, 501);
        check("rst_clear err_count", int'(err_count), 0);
        check("rst_clear busy", int'(busy), 0);
        exp_err_total = 0;
        $display("frame clear_reset: writes=%0d err_count=%0d", wr_addr_q.size() - base, err_count);

        // Loader still works after the reset
        frame_q = '{8'h55, 8'h01, 8'h01, 8'h23, 8'h0A, 8'hBC, 8'h15, 8'hAA};
        run_frame("plain_after_rst", 1, 'h123, 'hABC, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_mem_loader.md
Name: uart_mem_loader

Overview:
- Parametrised successor to the top-level UART RX byte framer.
- Consumes the uart_rx byte stream and decodes escaped, checksummed command frames into memory write bursts.
- Supports single-word writes and a full-memory clear. Holds the CPU in reset while busy, and counts framing errors.
- Sits between uart_rx and the memory mux at the FPGA top level.

Parameters:
- ADDR_W, 10, memory address width (1..16)
- DATA_W, 12, memory word width (1..16)
- START_BYTE, 8'h55, raw frame start
- STOP_BYTE, 8'hAA, raw frame stop
- ESC_BYTE, 8'h7D, escape prefix; the next byte is XORed with 8'h20

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- rx_data  in  8  received byte
- rx_valid  in  1  one-cycle strobe; rx_data is valid while high
- mem_wr_en  out  1  write strobe, one word per cycle
- mem_wr_addr  out  ADDR_W  write address
- mem_wr_data  out  DATA_W  write data
- busy  out  1  high from the first byte after START until the frame completes or aborts; used as the CPU hold/reset
- frame_ok  out  1  one-cycle pulse when a frame succeeds
- frame_err  out  1  one-cycle pulse on any error
- err_count  out  8  error counter, saturates at 255

Behaviour:
- Clocking and reset: one clock, clk. rst is synchronous and active-high.
- Reset values: every output is 0, the FSM is in IDLE, the escape flag is clear, and the checksum accumulator is 0.
- Derived constants: AB = ceil(ADDR_W/8) and DB = ceil(DATA_W/8).
- Frame format: START, CMD, payload, CHK, STOP.
  - CMD 8'h01 is WRITE; its payload is AB address bytes then DB data bytes, MSB first.
  - CMD 8'h02 is CLEAR; it has no payload.
  - Bits above ADDR_W/DATA_W are discarded.
- Checksum: the 8-bit sum of CMD, payload and CHK, all after unescaping, must equal 8'h00.
- Unescaping: a raw ESC sets the escape flag. The next non-START/STOP byte is XORed with 8'h20 and consumed as data. Raw START and STOP are never data.
- FSM states: IDLE, CMD, ADDR, DATA, CHK, STOP, WRITE, CLEAR.
- Transitions:
  - IDLE: raw START -> CMD. All other bytes are ignored with no error.
  - CMD: 01 -> ADDR; 02 -> CHK; any other value -> error, IDLE.
  - ADDR: after AB bytes -> DATA.
  - DATA: after DB bytes -> CHK.
  - CHK: one byte -> STOP.
  - STOP: raw STOP with good sum -> WRITE (cmd 01) or CLEAR (cmd 02).
  - STOP: raw STOP with bad sum -> error, IDLE.
  - STOP: any other byte -> error, IDLE.
- Resync:
  - A raw START in any receive state other than IDLE is an error (frame_err, err_count increment) and restarts at CMD in the same cycle.
  - A raw STOP in CMD, ADDR, DATA or CHK is an error and returns to IDLE.
- WRITE: lasts exactly 1 cycle.
  - mem_wr_en=1 with the decoded addr/data, and frame_ok=1, in the cycle after the STOP strobe.
  - Then -> IDLE.
- CLEAR: lasts 2^ADDR_W cycles.
  - mem_wr_en=1, mem_wr_data=0, and mem_wr_addr counts from 0 to 2^ADDR_W-1.
  - frame_ok pulses on the last cycle, then -> IDLE.
  - Any rx_valid during CLEAR is dropped and counted as an error; the clear continues.
- busy:
  - Rises in the cycle after the START strobe.
  - Falls in the cycle after the final WRITE/CLEAR cycle, or in the cycle after an abort to IDLE.
- Error rules:
  - frame_err is a single-cycle pulse.
  - err_count increments by exactly 1 per error event and holds at 255.
- Reset mid-CLEAR or mid-frame: mem_wr_en drops on the next clock edge and no further writes occur.
- Simultaneous events: rst takes priority over everything.

Decomposition:
- Package uart_loader_pkg:
  - state enum
  - CMD_WRITE and CMD_CLEAR constants
  - default START/STOP/ESC values
  - ESC_XOR = 8'h20
- Sub-module uart_unescape (combinational+flag): turns rx_data/rx_valid into byte, is_start, is_stop and data_valid, and owns the escape flag.

Test Plan:
- Plain write: frame 55 01 01 23 0A BC 15 AA -> one mem_wr_en cycle with addr 0x123, data 0xABC; frame_ok=1; err_count=0.
- Escaped write: frame 55 01 00 7D 75 00 7D 8A 00 AA -> mem_wr_en with addr 0x055, data 0x0AA; frame_ok.
- Bad checksum: the plain-write frame with CHK 16 -> frame_err pulse, err_count=1, no mem_wr_en, busy low afterwards.
- Resync: 55 01 01 followed by the full plain-write frame -> err_count=1, then a single write to 0x123 with data 0xABC.
- Clear: frame 55 02 FE AA -> 1024 consecutive mem_wr_en cycles covering addr 0..1023 with data 0; frame_ok on the last; busy high throughout. Assert rst at address 500 in a second run -> no writes after the next edge.
- Saturation and junk: 300 frames with a bad CMD 55 07 F9 AA -> err_count=255. Bytes 12 34 while in IDLE -> no error.
